// File: rtl/sram_port_arbiter.sv
// Purpose: shares one single-port SRAM between the fetch requester and the
//   execute-stage data requester; data has priority, a starvation counter
//   forces a fetch win after STARVE_LIMIT consecutive contested losses.
// Latency: grant/addr_ok are combinational (zero-cycle acceptance); the
//   data_ok and read data for a grant in cycle N appear in cycle N+1.
// Backpressure: the losing requester is simply not accepted (addr_ok = 0)
//   and keeps its request held until it wins; a new grant can issue every cycle.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   inst_req/inst_addr    fetch read request; inst_addr_ok accepts it
//   inst_data_ok/rdata    fetch read response, one cycle after the grant
//   data_req/wr/wstrb/addr/wdata   data request; data_addr_ok accepts it
//   data_data_ok/rdata    data response (reads and writes), one cycle later
//   sram_*                single SRAM port; sram_rdata valid cycle after read
module sram_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        sram_en,
   output logic [3:0]  sram_wen,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic       resp_valid_q, resp_valid_d;
   logic       resp_owner_q, resp_owner_d;   // 1 = data, 0 = fetch
   logic [3:0] starve_cnt_q, starve_cnt_d;

   logic both_req;
   logic grant_inst;
   logic grant_data;

   // Grant decision. Reset suppresses every grant so all outputs stay 0.
   always_comb begin
      both_req   = inst_req & data_req;
      grant_inst = 1'b0;
      grant_data = 1'b0;
      if (!reset) begin
         if (both_req) begin
            if (starve_cnt_q == LIMIT) begin
               grant_inst = 1'b1;
            end else begin
               grant_data = 1'b1;
            end
         end else begin
            grant_inst = inst_req;
            grant_data = data_req;
         end
      end
   end

   // SRAM port drive and acceptance.
   always_comb begin
      inst_addr_ok = grant_inst;
      data_addr_ok = grant_data;
      sram_en      = grant_inst | grant_data;
      sram_wen     = 4'h0;
      sram_addr    = 32'h0;
      sram_wdata   = 32'h0;
      if (grant_data) begin
         sram_addr  = data_addr;
         sram_wen   = data_wr ? data_wstrb : 4'h0;
         sram_wdata = data_wdata;
      end else if (grant_inst) begin
         sram_addr  = inst_addr;
      end
   end

   // Response steering; reset masks a response still in flight.
   always_comb begin
      inst_data_ok = ~reset & resp_valid_q & ~resp_owner_q;
      data_data_ok = ~reset & resp_valid_q &  resp_owner_q;
      inst_rdata   = reset ? 32'h0 : sram_rdata;
      data_rdata   = reset ? 32'h0 : sram_rdata;
   end

   // Next-state: response tracking and starvation counter.
   always_comb begin
      resp_valid_d = grant_inst | grant_data;
      resp_owner_d = grant_data;
      starve_cnt_d = starve_cnt_q;
      if (grant_inst || !inst_req) begin
         starve_cnt_d = 4'h0;
      end else if (both_req && grant_data) begin
         // Fetch lost a contested cycle; saturate at the forcing threshold.
         if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'h1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid_q <= 1'b0;
         resp_owner_q <= 1'b0;
         starve_cnt_q <= 4'h0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_owner_q <= resp_owner_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Purpose: self-checking bench for sram_port_arbiter with an SRAM model and a
//   request-level reference model (consecutive fetch losses, pending response,
//   shadow memory), directed plan steps followed by randomized traffic.
module tb_sram_port_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr, sram_wdata;
   logic [31:0] sram_rdata;

   sram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   // ---------------- SRAM model (256 words, aliased on addr[9:2]) ----------
   logic [31:0] mem [256];
   logic [31:0] ref_mem [256];
   bit          mem_filled = 1'b0;
   logic [31:0] sram_tmp;

   function automatic logic [31:0] init_word(input int i);
      return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   always @(posedge clk) begin
      if (!mem_filled) begin
         for (int i = 0; i < 256; i++) mem[i] = init_word(i);
         mem_filled = 1'b1;
      end else if (sram_en) begin
         sram_rdata <= mem[sram_addr[9:2]];
         sram_tmp = mem[sram_addr[9:2]];
         for (int b = 0; b < 4; b++)
            if (sram_wen[b]) sram_tmp[8*b +: 8] = sram_wdata[8*b +: 8];
         mem[sram_addr[9:2]] = sram_tmp;
      end
   end

   // ---------------- reference model state ---------------------------------
   int          m_losses = 0;      // consecutive contested cycles fetch lost
   bit          m_rv = 1'b0;       // a response is due this cycle
   bit          m_ro = 1'b0;       // its owner (1 = data)
   bit          m_rread = 1'b0;    // it carries read data
   logic [31:0] m_rd = 32'h0;
   bit          m_g_inst, m_g_data;

   logic        obs_iok, obs_dok, obs_idok, obs_ddok;
   logic [31:0] obs_irdata, obs_drdata;
   logic [3:0]  obs_wen;

   int n_pass = 0, n_fail = 0, n_total = 0;

   int exp_cnt_c[10]  = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
   bit exp_iok_c[10]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
   int exp_cnt_f[8]   = '{1, 2, 0, 1, 2, 3, 4, 0};
   bit exp_iok_f[8]   = '{0, 0, 0, 0, 0, 0, 0, 1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_idle();
      inst_req = 1'b0; inst_addr = 32'h0;
      data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
      data_addr = 32'h0; data_wdata = 32'h0;
   endtask

   task automatic dreq(input bit wr, input logic [3:0] st, input logic [31:0] a,
                       input logic [31:0] wd);
      data_req = 1'b1; data_wr = wr; data_wstrb = st; data_addr = a; data_wdata = wd;
   endtask

   // One clock cycle: inputs are already applied (posedge+1). Checks at the
   // falling edge, then advances the model across the rising edge.
   task automatic cycle();
      bit          e_gi, e_gd, contested, rst_now;
      logic [3:0]  e_wen;
      logic [7:0]  idx;
      #4;
      rst_now   = reset;
      contested = inst_req && data_req;
      e_gi = 1'b0; e_gd = 1'b0;
      if (!rst_now) begin
         if (contested) begin
            if (m_losses >= LIMIT) e_gi = 1'b1; else e_gd = 1'b1;
         end else begin
            e_gi = inst_req; e_gd = data_req;
         end
      end
      e_wen = (e_gd && data_wr) ? data_wstrb : 4'h0;

      chk("inst_addr_ok", {31'h0, inst_addr_ok}, {31'h0, e_gi});
      chk("data_addr_ok", {31'h0, data_addr_ok}, {31'h0, e_gd});
      chk("sram_en", {31'h0, sram_en}, {31'h0, e_gi | e_gd});
      chk("sram_wen", {28'h0, sram_wen}, {28'h0, e_wen});
      if (e_gd) begin
         chk("sram_addr_d", sram_addr, data_addr);
         chk("sram_wdata_d", sram_wdata, data_wdata);
      end else if (e_gi) begin
         chk("sram_addr_i", sram_addr, inst_addr);
         chk("sram_wdata_i", sram_wdata, 32'h0);
      end
      chk("inst_data_ok", {31'h0, inst_data_ok}, {31'h0, !rst_now && m_rv && !m_ro});
      chk("data_data_ok", {31'h0, data_data_ok}, {31'h0, !rst_now && m_rv && m_ro});
      if (rst_now) begin
         chk("rst_inst_rdata", inst_rdata, 32'h0);
         chk("rst_data_rdata", data_rdata, 32'h0);
      end else if (m_rv && m_rread) begin
         if (m_ro) chk("data_rdata", data_rdata, m_rd);
         else      chk("inst_rdata", inst_rdata, m_rd);
      end

      obs_iok = inst_addr_ok; obs_dok = data_addr_ok;
      obs_idok = inst_data_ok; obs_ddok = data_data_ok;
      obs_irdata = inst_rdata; obs_drdata = data_rdata; obs_wen = sram_wen;

      @(posedge clk);
      #1;
      if (rst_now) begin
         m_losses = 0; m_rv = 1'b0; m_ro = 1'b0; m_rread = 1'b0;
      end else begin
         if (contested && e_gd)      m_losses++;
         else if (e_gi || !inst_req) m_losses = 0;
         m_rv    = e_gi | e_gd;
         m_ro    = e_gd;
         m_rread = e_gi || (e_gd && !data_wr);
         idx     = e_gd ? data_addr[9:2] : inst_addr[9:2];
         if (m_rread) m_rd = ref_mem[idx];
         if (e_gd && data_wr)
            for (int b = 0; b < 4; b++)
               if (data_wstrb[b]) ref_mem[idx][8*b +: 8] = data_wdata[8*b +: 8];
      end
      m_g_inst = e_gi; m_g_data = e_gd;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      reset = 1'b1;
      set_idle();
      @(posedge clk);
      #1;

      // Reset state, including requests presented while reset is high.
      cycle();
      inst_req = 1'b1; inst_addr = 32'h20; dreq(1'b1, 4'hF, 32'h24, 32'hDEAD_BEEF);
      cycle();
      chk("rst_no_grant", {31'h0, obs_iok | obs_dok}, 32'h0);
      chk("rst_wen", {28'h0, obs_wen}, 32'h0);
      chk("rst_cnt", {28'h0, dut.starve_cnt_q}, 32'h0);
      reset = 1'b0; set_idle();
      cycle();

      // Single fetch (preload the word with a full data write first).
      dreq(1'b1, 4'hF, 32'h1C00_0000, 32'h0280_0C0C);
      cycle();
      set_idle(); inst_req = 1'b1; inst_addr = 32'h1C00_0000;
      cycle();
      chk("fetch_aok", {31'h0, obs_iok}, 32'h1);
      chk("fetch_wen", {28'h0, obs_wen}, 32'h0);
      set_idle();
      cycle();
      chk("fetch_dok", {31'h0, obs_idok}, 32'h1);
      chk("fetch_rdata", obs_irdata, 32'h0280_0C0C);
      chk("fetch_no_ddok", {31'h0, obs_ddok}, 32'h0);

      // Partial write then read-back.
      dreq(1'b1, 4'hF, 32'h100, 32'h1122_3344);
      cycle();
      dreq(1'b1, 4'b0011, 32'h100, 32'hAABB_CCDD);
      cycle();
      chk("wr_wen", {28'h0, obs_wen}, 32'h3);
      dreq(1'b0, 4'h0, 32'h100, 32'h0);
      cycle();
      chk("wr_dok", {31'h0, obs_ddok}, 32'h1);
      set_idle();
      cycle();
      chk("rd_dok", {31'h0, obs_ddok}, 32'h1);
      chk("rd_rdata", obs_drdata, 32'h1122_CCDD);

      // Continuous contention.
      set_idle();
      cycle();
      inst_req = 1'b1; inst_addr = 32'h80; dreq(1'b0, 4'h0, 32'h40, 32'h0);
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("contend_grant", {31'h0, obs_iok}, {31'h0, exp_iok_c[i]});
         chk("contend_cnt", {28'h0, dut.starve_cnt_q}, 32'(exp_cnt_c[i]));
      end

      // Fetch drops out for one cycle and must start over.
      set_idle();
      cycle();
      for (int i = 0; i < 8; i++) begin
         inst_req = (i != 2); inst_addr = 32'h84; dreq(1'b0, 4'h0, 32'h44, 32'h0);
         cycle();
         chk("drop_grant", {31'h0, obs_iok}, {31'h0, exp_iok_f[i]});
         chk("drop_cnt", {28'h0, dut.starve_cnt_q}, 32'(exp_cnt_f[i]));
      end

      // Reset right after a data read grant.
      set_idle();
      inst_req = 1'b1; inst_addr = 32'h88; dreq(1'b0, 4'h0, 32'h100, 32'h0);
      cycle();
      cycle();
      chk("pre_rst_dok", {31'h0, obs_dok}, 32'h1);
      reset = 1'b1;
      cycle();
      chk("rst_drop_ddok", {31'h0, obs_ddok}, 32'h0);
      chk("rst_drop_en", {31'h0, obs_iok | obs_dok}, 32'h0);
      reset = 1'b0;
      chk("post_rst_cnt", {28'h0, dut.starve_cnt_q}, 32'h0);
      cycle();
      chk("post_rst_grant", {31'h0, obs_dok}, 32'h1);
      set_idle();
      cycle();
      chk("post_rst_rdata", obs_drdata, 32'h1122_CCDD);

      // Randomized traffic; requests held until the model says accepted.
      set_idle();
      for (int n = 0; n < 400; n++) begin
         if (!inst_req && ($urandom_range(2) != 0)) begin
            inst_req = 1'b1;
            inst_addr = {22'h0, 8'($urandom), 2'b00};
         end
         if (!data_req && ($urandom_range(2) != 0)) begin
            dreq(1'($urandom), 4'($urandom), {22'h0, 8'($urandom), 2'b00}, $urandom);
         end
         reset = ($urandom_range(49) == 0);
         cycle();
         if (m_g_inst) inst_req = 1'b0;
         if (m_g_data) data_req = 1'b0;
      end
      reset = 1'b0;
      set_idle();
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
